// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//     SA_DEFAULT_WIDTH : default operand/sum width in bits
//     sa_state_e       : controller state encoding (IDLE / SHIFT / FINISH)
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int SA_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    FINISH = 2'b10
  } sa_state_e;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit combinational full adder; the single arithmetic cell reused every
//   cycle by the serial adder.
//   Ports:
//     a, b  : operand bits
//     cin   : carry in
//     sum   : a ^ b ^ cin
//     cout  : carry out (majority of a, b, cin)
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half;

  assign half = a ^ b;
  assign sum  = half ^ cin;
  assign cout = (a & b) | (cin & half);

endmodule : full_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder. An accepted start captures a and b; the adder then spends
//   exactly WIDTH cycles in SHIFT, feeding one bit pair per cycle (LSB first)
//   through a single full_adder cell, and lands in FINISH where done pulses and
//   the registered sum/carry_out hold the new result. A start seen in FINISH is
//   accepted immediately, so back-to-back additions have no idle gap.
//
//   Parameters:
//     WIDTH     : operand and sum width in bits (2..32)
//   Ports:
//     clk       : clock, rising edge
//     rst       : synchronous active-high reset
//     start     : add request, sampled only in IDLE or FINISH
//     a, b      : operands, captured on an accepted start
//     busy      : high while in SHIFT
//     done      : high for the single FINISH cycle
//     sum       : registered (a + b) mod 2^WIDTH, held until the next FINISH
//     carry_out : registered carry out of bit WIDTH-1
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  // One spare counter bit keeps the count from wrapping for any legal WIDTH.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sa_state_e        state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] psum;
  logic             cy;
  logic [CNT_W-1:0] cnt;

  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] psum_next;
  logic             accept;
  logic             last_bit;

  full_adder u_fa (
    .a    (opa[0]),
    .b    (opb[0]),
    .cin  (cy),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New result bit enters at the MSB; after WIDTH shifts the first bit computed
  // (bit 0) has walked down to psum[0]. The widened shift keeps every psum bit
  // in the expression; the cast drops the vacated top bit.
  assign psum_next = WIDTH'({fa_sum, psum} >> 1);

  assign accept   = start && ((state == IDLE) || (state == FINISH));
  assign last_bit = (cnt == CNT_LAST);

  // Status outputs decode the state register only, so no input reaches an
  // output without passing through a flop.
  assign busy = (state == SHIFT);
  assign done = (state == FINISH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      psum      <= '0;
      cy        <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (accept) begin
            opa   <= a;
            opb   <= b;
            cy    <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end

        SHIFT: begin
          // One bit position per cycle; operands drain toward bit 0.
          opa  <= opa >> 1;
          opb  <= opb >> 1;
          psum <= psum_next;
          cy   <= fa_cout;
          cnt  <= cnt + CNT_ONE;
          if (last_bit) begin
            // Publish the completed result on the same edge that finishes it.
            sum       <= psum_next;
            carry_out <= fa_cout;
            state     <= FINISH;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed bench for serial_adder: an 8-bit instance for latency, wrap,
//   back-to-back and reset-abort behaviour, and a 4-bit instance swept over
//   every operand pair.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8;
  logic [7:0] a8, b8, sum8;
  logic       busy8, done8, co8;

  logic       start4;
  logic [3:0] a4, b4, sum4;
  logic       busy4, done4, co4;

  int checks   = 0;
  int failures = 0;
  int viol     = 0;
  int done_cnt4 = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .a         (a8),
    .b         (b8),
    .busy      (busy8),
    .done      (done8),
    .sum       (sum8),
    .carry_out (co8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .start     (start4),
    .a         (a4),
    .b         (b4),
    .busy      (busy4),
    .done      (done4),
    .sum       (sum4),
    .carry_out (co4)
  );

  always @(negedge clk) begin
    if ((busy8 && done8) || (busy4 && done4)) viol++;
    if (done4) done_cnt4++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exhausted, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] es, input logic ec);
    int n;
    int bc;
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n  = 0;
    bc = 0;
    while (!done8 && n < 30) begin
      if (busy8) bc++;
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd8);
    chk({tag, "_busy_cycles"}, 32'(bc), 32'd8);
    chk({tag, "_sum"}, 32'(sum8), 32'(es));
    chk({tag, "_cout"}, 32'(co8), 32'(ec));
  endtask

  initial begin
    int n;
    int cnt;
    int acc4;
    int lat_bad;

    rst = 1'b1;
    start8 = 1'b1;   // reset must win over start
    start4 = 1'b0;
    a8 = 8'd77; b8 = 8'd88;
    a4 = '0;    b4 = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(co8), 32'd0);
    chk("rst_sum4", 32'(sum4), 32'd0);

    // First edge after reset release accepts start.
    rst = 1'b0;
    run8("add_3_5", 8'd3, 8'd5, 8'd8, 1'b0);

    // Result holds through IDLE.
    tick();
    chk("hold_idle_done", 32'(done8), 32'd0);
    chk("hold_idle_sum", 32'(sum8), 32'd8);
    tick();
    chk("hold_idle_busy", 32'(busy8), 32'd0);

    run8("add_255_1", 8'd255, 8'd1, 8'd0, 1'b1);
    run8("add_200_100", 8'd200, 8'd100, 8'd44, 1'b1);

    // Result holds while the next addition is shifting.
    tick();
    a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    chk("hold_shift_sum", 32'(sum8), 32'd44);
    chk("hold_shift_cout", 32'(co8), 32'd1);
    n = 0;
    while (!done8 && n < 30) begin tick(); n++; end
    chk("add_1_2_sum", 32'(sum8), 32'd3);
    chk("add_1_2_cout", 32'(co8), 32'd0);
    tick();

    // start held high; operands change mid-SHIFT; back-to-back from FINISH.
    a8 = 8'd10; b8 = 8'd20; start8 = 1'b1;
    tick();
    n = 0;
    while (!done8 && n < 30) begin
      if (n == 3) begin a8 = 8'd1; b8 = 8'd1; end
      tick();
      n++;
    end
    chk("b2b_first_latency", 32'(n), 32'd8);
    chk("b2b_first_sum", 32'(sum8), 32'd30);
    chk("b2b_first_cout", 32'(co8), 32'd0);
    n = 0;
    do begin tick(); n++; end while (!done8 && n < 30);
    chk("b2b_gap", 32'(n), 32'd9);
    chk("b2b_second_sum", 32'(sum8), 32'd2);
    start8 = 1'b0;
    tick();

    // Reset in the middle of SHIFT aborts without a result.
    a8 = 8'd100; b8 = 8'd27; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_sum", 32'(sum8), 32'd0);
    chk("abort_cout", 32'(co8), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done8 || busy8) cnt++;
    end
    chk("abort_quiet", 32'(cnt), 32'd0);
    run8("add_100_27", 8'd100, 8'd27, 8'd127, 1'b0);
    tick();

    // 4-bit sweep over all operand pairs.
    acc4 = 0;
    lat_bad = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        a4 = 4'(x);
        b4 = 4'(y);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        if (busy4) acc4++;
        n = 0;
        while (!done4 && n < 12) begin tick(); n++; end
        if (n != 4) lat_bad++;
        chk($sformatf("w4_%0d_plus_%0d", x, y), 32'({co4, sum4}), 32'(x + y));
      end
    end
    tick();
    tick();
    chk("w4_latency_errors", 32'(lat_bad), 32'd0);
    chk("w4_accepts", 32'(acc4), 32'd256);
    chk("w4_done_count", 32'(done_cnt4), 32'(acc4));
    chk("busy_done_exclusive", 32'(viol), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_adder
